// File: rtl/fpu_pkg.sv
// Shared FP-unit definitions: converter latency default and the requester tag
// that travels alongside a shared converter's pipeline.
package fpu_pkg;

  localparam int FCVT_LAT = 3;

  // Wide enough for up to four requesters sharing one unit.
  localparam int TAG_ID_W = 2;

  typedef struct packed {
    logic                issued;
    logic                live;
    logic [TAG_ID_W-1:0] id;
  } fcvt_tag_t;

  // Advance a tag by one stage; a flush kills the entry but keeps its slot
  // so the converter's valid timing can still be checked against it.
  function automatic fcvt_tag_t tag_advance(input fcvt_tag_t t, input logic flush);
    fcvt_tag_t r;
    r      = t;
    r.live = t.live & ~flush;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NREQ requests, one-hot grant, pointer moves to the winner
// on accept so the next search starts just past it.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id,
  output logic            accept
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned (which would infer a latch).
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (en && !accept && req[IW'(idx)]) begin
        accept          = 1'b1;
        grant[IW'(idx)] = 1'b1;
        grant_id        = IW'(idx);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NREQ - 1);
    end else if (accept) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/fcvt_arbiter.sv
// Shares one fixed-latency float-to-int converter among NREQ requesters,
// routing results back by a tag pipeline that also checks converter timing.
module fcvt_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = FCVT_LAT,
  parameter int W    = 32,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int IFW  = $clog2(LAT + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic              flush,
  output logic              cvt_valid,
  output logic [W-1:0]      cvt_a,
  input  logic              cvt_valid_out,
  input  logic [W-1:0]      cvt_y,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_y,
  output logic [IFW-1:0]    in_flight,
  output logic              err
);

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            accept;
  logic            arb_en;
  logic [IW-1:0]   iss_id;
  fcvt_tag_t       tags [LAT];
  fcvt_tag_t       last;
  logic            hit;

  assign arb_en    = ~rst & ~flush;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (arb_en),
    .grant    (grant),
    .grant_id (grant_id),
    .accept   (accept)
  );

  // Issue register: the operand is held between issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      cvt_valid <= 1'b0;
      cvt_a     <= '0;
      iss_id    <= '0;
    end else begin
      cvt_valid <= accept;
      if (accept) begin
        cvt_a  <= req_a[int'(grant_id)*W +: W];
        iss_id <= grant_id;
      end
    end
  end

  // NOTE: the tag stages are control state, not data storage: their issued
  // bits must be known after reset, so every stage is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      tags[0] <= '{issued: cvt_valid, live: cvt_valid & ~flush, id: TAG_ID_W'(iss_id)};
      for (int k = 1; k < LAT; k++) begin
        tags[k] <= tag_advance(tags[k-1], flush);
      end
    end
  end

  assign last = tags[LAT-1];
  assign hit  = last.issued & cvt_valid_out;

  // Entries sitting in the last stage during a flush are killed too.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= hit & last.live & ~flush;
      if (hit) begin
        rsp_id <= last.id[IW-1:0];
        rsp_y  <= cvt_y;
      end
      if (cvt_valid_out != last.issued) begin
        err <= 1'b1;
      end
    end
  end

  // No accept can coincide with a flush, and a response visible during the
  // flush is already accounted for by clearing to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      in_flight <= '0;
    end else if (accept && !rsp_valid) begin
      in_flight <= in_flight + IFW'(1);
    end else if (!accept && rsp_valid) begin
      in_flight <= in_flight - IFW'(1);
    end
  end

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Randomized scoreboard bench for fcvt_arbiter with a behavioural converter stub
// and a queue-based model of arbitration, latency, flush and reset.
module tb_fcvt_arbiter;

  localparam int NREQ = 2;
  localparam int LAT  = 3;
  localparam int W    = 32;
  localparam int IW   = 1;
  localparam int IFW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic              cvt_valid;
  logic [W-1:0]      cvt_a;
  logic              cvt_valid_out;
  logic [W-1:0]      cvt_y;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_y;
  logic [IFW-1:0]    in_flight;
  logic              err;

  fcvt_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .flush         (flush),
    .cvt_valid     (cvt_valid),
    .cvt_a         (cvt_a),
    .cvt_valid_out (cvt_valid_out),
    .cvt_y         (cvt_y),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_y         (rsp_y),
    .in_flight     (in_flight),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Exact single-precision encoding of a small integer.
  function automatic logic [31:0] int_to_float(input int v);
    logic [31:0] m;
    int          p;
    logic [7:0]  e;
    logic [22:0] mant;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e    = 8'(127 + p);
    mant = 23'(m << (23 - p));
    return {(v < 0), e, mant};
  endfunction

  // Truncating float-to-int, used only by the converter stub.
  function automatic logic [31:0] f2i(input logic [31:0] a);
    int          sh;
    logic [31:0] m, r;
    if (a[30:23] < 8'd127) return 32'h0;
    sh = int'(a[30:23]) - 127;
    m  = {8'h0, 1'b1, a[22:0]};
    if (sh >= 23) r = m << (sh - 23);
    else          r = m >> (23 - sh);
    return a[31] ? -r : r;
  endfunction

  // Converter stub with selectable latency, reset by the same rst.
  int          cvt_lat = LAT;
  logic        vpipe [8];
  logic [31:0] ypipe [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        vpipe[k] <= 1'b0;
        ypipe[k] <= 32'h0;
      end
    end else begin
      vpipe[0] <= cvt_valid;
      ypipe[0] <= f2i(cvt_a);
      for (int k = 1; k < 8; k++) begin
        vpipe[k] <= vpipe[k-1];
        ypipe[k] <= ypipe[k-1];
      end
    end
  end
  assign cvt_valid_out = vpipe[cvt_lat-1];
  assign cvt_y         = ypipe[cvt_lat-1];

  // Reference model: expected responses with the cycle they must appear in.
  typedef struct {
    int id;
    int y;
    int due;
  } exp_t;

  exp_t q[$];
  int   val [NREQ];
  int   ptr_m      = NREQ - 1;
  bit   fault_mode = 1'b0;
  bit   check_en   = 1'b0;
  int   err_due    = -1;

  task automatic step(input logic [NREQ-1:0] v, input bit fl, input bit r);
    int              w;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    req_valid = v;
    flush     = fl;
    rst       = r;
    for (int i = 0; i < NREQ; i++) req_a[i*W +: W] = int_to_float(val[i]);
    #1;
    w = -1;
    if (!r && !fl) begin
      for (int off = 1; off <= NREQ; off++) begin
        if (w < 0 && v[(ptr_m + off) % NREQ]) w = (ptr_m + off) % NREQ;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    if (check_en) check("req_ready", 32'(req_ready), 32'(eg));
    if (w >= 0) begin
      ptr_m = w;
      if (fault_mode) begin
        if (err_due < 0) err_due = cyc + LAT + 2;
      end else begin
        q.push_back('{w, val[w], cyc + LAT + 2});
      end
    end
    if (fl) q.delete();
    if (r) begin
      q.delete();
      ptr_m   = NREQ - 1;
      err_due = -1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  // Monitor: occupancy and error flag every cycle, responses against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (check_en) begin
      if (!fault_mode) check("in_flight", 32'(in_flight), 32'(q.size()));
      check("err", 32'(err), 32'(err_due >= 0 && cyc >= err_due));
      if (q.size() > 0 && q[0].due < cyc) begin
        n_checks++;
        $display("FAIL rsp_missing at cycle %0d: got no response, expected id %0d due %0d",
                 cyc, q[0].id, q[0].due);
        void'(q.pop_front());
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected at cycle %0d: got id %0d y %0h, expected none",
                   cyc, rsp_id, rsp_y);
        end else begin
          e = q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_y", rsp_y, 32'(e.y));
          check("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within bound");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    for (int i = 0; i < NREQ; i++) val[i] = 0;
    repeat (3) step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("reset_cvt_valid", 32'(cvt_valid), 0);
    check("reset_cvt_a", cvt_a, 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_y", rsp_y, 0);
    check("reset_in_flight", 32'(in_flight), 0);
    check("reset_err", 32'(err), 0);
    check_en = 1'b1;

    // Single request from requester 0 with 1.0.
    val[0] = 1;
    step(2'b01, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("issue_valid", 32'(cvt_valid), 1);
    check("issue_operand", cvt_a, 32'h3F800000);
    idle(8);

    // Contention: -50.0 against 10.0.
    val[0] = -50;
    val[1] = 10;
    repeat (4) step(2'b11, 1'b0, 1'b0);
    idle(8);

    // Flush one cycle after three back-to-back accepts.
    for (int i = 0; i < 3; i++) begin
      val[0] = rnd_val();
      step(2'b01, 1'b0, 1'b0);
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    check("flush_in_flight", 32'(in_flight), 0);
    idle(8);

    // Continuous stream from requester 1.
    for (int i = 0; i < 20; i++) begin
      val[1] = rnd_val();
      step(2'b10, 1'b0, 1'b0);
      if (i == 12) check("stream_in_flight", 32'(in_flight), 5);
    end
    idle(8);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < NREQ; j++) val[j] = rnd_val();
      step(NREQ'($urandom), ($urandom_range(0, 24) == 0), 1'b0);
    end
    idle(8);

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) begin
      val[0] = rnd_val();
      step(2'b01, 1'b0, 1'b0);
    end
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    check("rst_cvt_valid", 32'(cvt_valid), 0);
    check("rst_cvt_a", cvt_a, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_in_flight", 32'(in_flight), 0);
    step(2'b11, 1'b0, 1'b0);
    check("rst_first_grant", 32'(req_ready), 32'b01);
    idle(8);

    // Converter one cycle too slow: sticky error, no responses.
    fault_mode = 1'b1;
    cvt_lat    = LAT + 1;
    for (int i = 0; i < 3; i++) begin
      val[0] = rnd_val();
      step(2'b01, 1'b0, 1'b0);
      idle(3);
    end
    idle(8);
    check("fault_err_sticky", 32'(err), 1);
    step('0, 1'b0, 1'b1);
    fault_mode = 1'b0;
    cvt_lat    = LAT;
    step('0, 1'b0, 1'b0);
    check("fault_err_cleared", 32'(err), 0);
    idle(4);

    check("drain_queue", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
